// File: rtl/spi_reg_bridge.sv
// spi_reg_bridge: turns a byte stream from an SPI byte slave into register-file
// reads and writes. The first byte is a command (bit7 = write, low bits = address).
`default_nettype none

module spi_reg_bridge #(
    parameter int ADDR_W   = 7,
    parameter int AUTO_INC = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cs_active,
    input  logic              rx_valid,
    input  logic [7:0]        rx_byte,
    output logic              tx_load,
    output logic [7:0]        tx_byte,
    output logic [ADDR_W-1:0] reg_addr,
    output logic              reg_rd_en,
    input  logic [7:0]        reg_rd_data,
    output logic              reg_wr_en,
    output logic [7:0]        reg_wr_data,
    output logic              overrun
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        CMD      = 3'd1,
        RD_ISSUE = 3'd2,
        RD_CAPT  = 3'd3,
        RD_LOAD  = 3'd4,
        RD_READY = 3'd5,
        WR_READY = 3'd6
    } state_t;

    localparam logic [ADDR_W-1:0] ADDR_STEP = ADDR_W'(AUTO_INC != 0);

    state_t     state;
    state_t     state_nxt;
    logic       cs_q;
    logic       cs_rise;
    logic       cs_fall;
    logic       rx_ok;
    logic       rd_busy;
    logic       wr_pend;
    logic [7:0] capt_q;
    logic [7:0] tx_hold;

    assign cs_rise = cs_active & ~cs_q;
    assign cs_fall = ~cs_active & cs_q;
    assign rx_ok   = rx_valid & cs_active;
    assign rd_busy = (state == RD_ISSUE) || (state == RD_CAPT) || (state == RD_LOAD);

    // Strobes are qualified with cs_active so nothing leaves the block in the
    // cycle chip select drops.
    assign reg_rd_en = (state == RD_ISSUE) && cs_active;
    assign tx_load   = (state == RD_LOAD) && cs_active;
    assign reg_wr_en = wr_pend && cs_active;
    assign tx_byte   = tx_load ? capt_q : tx_hold;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (cs_fall) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:     if (cs_rise) state_nxt = CMD;
                CMD:      if (rx_ok) state_nxt = rx_byte[7] ? WR_READY : RD_ISSUE;
                RD_ISSUE: state_nxt = RD_CAPT;
                RD_CAPT:  state_nxt = RD_LOAD;
                RD_LOAD:  state_nxt = RD_READY;
                RD_READY: if (rx_ok) state_nxt = RD_ISSUE;
                WR_READY: state_nxt = WR_READY;
                default:  state_nxt = IDLE;
            endcase
        end
    end

    // cs_q resets high so a chip select already asserted at reset release is
    // not mistaken for a new transaction.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cs_q        <= 1'b1;
            reg_addr    <= '0;
            wr_pend     <= 1'b0;
            reg_wr_data <= 8'h00;
            capt_q      <= 8'h00;
            tx_hold     <= 8'h00;
            overrun     <= 1'b0;
        end else begin
            cs_q    <= cs_active;
            wr_pend <= 1'b0;

            if (state == CMD && rx_ok) begin
                reg_addr <= rx_byte[ADDR_W-1:0];
            end else if (reg_rd_en || reg_wr_en) begin
                reg_addr <= reg_addr + ADDR_STEP;
            end

            if (state == WR_READY && rx_ok) begin
                wr_pend     <= 1'b1;
                reg_wr_data <= rx_byte;
            end

            if (state == RD_CAPT && cs_active) begin
                capt_q <= reg_rd_data;
            end

            if (tx_load) begin
                tx_hold <= capt_q;
            end

            if (cs_rise) begin
                overrun <= 1'b0;
            end else if (rx_ok && rd_busy) begin
                overrun <= 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_spi_reg_bridge.sv
// Bench for spi_reg_bridge: cycle-schedule reference model plus directed literal checks.
`default_nettype none

module tb_spi_reg_bridge;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cs_active = 1'b0;
    logic       rx_valid = 1'b0;
    logic [7:0] rx_byte = 8'h00;
    logic       tx_load;
    logic [7:0] tx_byte;
    logic [6:0] reg_addr;
    logic       reg_rd_en;
    logic [7:0] reg_rd_data;
    logic       reg_wr_en;
    logic [7:0] reg_wr_data;
    logic       overrun;

    int n_chk = 0;
    int n_fail = 0;

    logic [7:0]  mem     [128];
    logic [7:0]  exp_mem [128];
    logic [7:0]  rd_q = 8'h00;
    logic [7:0]  tx_log [$];
    logic [6:0]  rd_log [$];
    logic [15:0] wr_log [$];

    spi_reg_bridge dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cs_active  (cs_active),
        .rx_valid   (rx_valid),
        .rx_byte    (rx_byte),
        .tx_load    (tx_load),
        .tx_byte    (tx_byte),
        .reg_addr   (reg_addr),
        .reg_rd_en  (reg_rd_en),
        .reg_rd_data(reg_rd_data),
        .reg_wr_en  (reg_wr_en),
        .reg_wr_data(reg_wr_data),
        .overrun    (overrun)
    );

    always #5 clk = ~clk;

    // Register file with one-cycle read latency.
    always @(posedge clk) begin
        if (reg_rd_en) rd_q <= mem[reg_addr];
        if (reg_wr_en) mem[reg_addr] <= reg_wr_data;
    end
    assign reg_rd_data = rd_q;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: each accepted byte schedules its effects by cycle number.
    int         cyc_n = 0;
    int         rs = -1;
    int         phase = 0;
    bit         m_cs_prev = 1'b1;
    logic [6:0] m_addr = 7'h00;
    logic       m_ovr = 1'b0;
    logic [7:0] m_tx = 8'h00;
    logic [7:0] m_pend = 8'h00;
    logic [7:0] m_wrd = 8'h00;
    bit         m_wrp = 1'b0;

    always @(negedge clk) begin
        if (!rst_n) begin
            rs = -1; phase = 0; m_cs_prev = 1'b1; m_addr = 7'h00; m_ovr = 1'b0;
            m_tx = 8'h00; m_pend = 8'h00; m_wrd = 8'h00; m_wrp = 1'b0;
        end else begin
            bit busy, e_rd, e_ld, e_wr, rise, fall;
            logic [7:0] e_tx;
            busy = (rs >= 0) && (cyc_n <= rs + 3);
            e_rd = (rs >= 0) && (cyc_n == rs + 1) && cs_active;
            e_ld = (rs >= 0) && (cyc_n == rs + 3) && cs_active;
            e_wr = m_wrp && cs_active;
            e_tx = e_ld ? m_pend : m_tx;

            chk("reg_rd_en", 32'(reg_rd_en), 32'(e_rd));
            chk("reg_wr_en", 32'(reg_wr_en), 32'(e_wr));
            chk("tx_load", 32'(tx_load), 32'(e_ld));
            chk("tx_byte", 32'(tx_byte), 32'(e_tx));
            chk("reg_addr", 32'(reg_addr), 32'(m_addr));
            chk("reg_wr_data", 32'(reg_wr_data), 32'(m_wrd));
            chk("overrun", 32'(overrun), 32'(m_ovr));
            chk("rd_wr_exclusive", 32'(reg_rd_en & reg_wr_en), 32'(0));

            if (e_rd) begin m_pend = exp_mem[m_addr]; m_addr = m_addr + 7'd1; end
            if (e_ld) begin m_tx = m_pend; rs = -1; end
            if (e_wr) begin exp_mem[m_addr] = m_wrd; m_addr = m_addr + 7'd1; m_wrp = 1'b0; end

            fall = m_cs_prev && !cs_active;
            rise = !m_cs_prev && cs_active;
            if (fall) begin
                phase = 0; rs = -1; m_wrp = 1'b0;
            end else if (rise) begin
                if (phase == 0) phase = 1;
                m_ovr = 1'b0;
            end else if (rx_valid && cs_active) begin
                case (phase)
                    1: begin
                        m_addr = rx_byte[6:0];
                        if (rx_byte[7]) phase = 3;
                        else begin phase = 2; rs = cyc_n; end
                    end
                    2: if (busy) m_ovr = 1'b1; else rs = cyc_n;
                    3: begin m_wrp = 1'b1; m_wrd = rx_byte; end
                    default: ;
                endcase
            end
            m_cs_prev = cs_active;
            cyc_n++;
        end
    end

    // Output event logs for the directed literal checks.
    always @(negedge clk) begin
        if (rst_n) begin
            if (tx_load) tx_log.push_back(tx_byte);
            if (reg_rd_en) rd_log.push_back(reg_addr);
            if (reg_wr_en) wr_log.push_back({1'b0, reg_addr, reg_wr_data});
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic send(input logic [7:0] b, input int gap);
        rx_valid = 1'b1; rx_byte = b;
        cyc(1);
        rx_valid = 1'b0;
        cyc(gap);
    endtask

    task automatic cs_on();
        cs_active = 1'b1; cyc(2);
    endtask

    task automatic cs_off();
        cs_active = 1'b0; cyc(3);
    endtask

    task automatic clr_logs();
        tx_log.delete(); rd_log.delete(); wr_log.delete();
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_tx_load"}, 32'(tx_load), 32'(0));
        chk({tag, "_rd_en"}, 32'(reg_rd_en), 32'(0));
        chk({tag, "_wr_en"}, 32'(reg_wr_en), 32'(0));
        chk({tag, "_overrun"}, 32'(overrun), 32'(0));
        chk({tag, "_tx_byte"}, 32'(tx_byte), 32'(0));
        chk({tag, "_reg_addr"}, 32'(reg_addr), 32'(0));
        chk({tag, "_wr_data"}, 32'(reg_wr_data), 32'(0));
    endtask

    logic [7:0] burst_exp [7];

    initial begin
        for (int i = 0; i < 128; i++) begin
            mem[i] = 8'($urandom_range(0, 255));
        end
        burst_exp = '{8'h41, 8'h52, 8'h47, 8'h55, 8'h53, 8'h01, 8'h5A};
        for (int i = 0; i < 7; i++) mem[i] = burst_exp[i];
        for (int i = 0; i < 128; i++) exp_mem[i] = mem[i];

        #1;
        chk_reset_outputs("reset");
        cyc(2);
        rst_n = 1'b1;
        cyc(2);

        // Read burst over "ARGUS",0x01 then address 0x06.
        clr_logs();
        cs_on();
        send(8'h00, 4);
        for (int i = 0; i < 6; i++) send(8'hFF, 4);
        cyc(2);
        chk("burst_tx_count", 32'(tx_log.size()), 32'(7));
        chk("burst_rd_count", 32'(rd_log.size()), 32'(7));
        for (int i = 0; i < 7; i++) begin
            chk("burst_tx_byte", (i < tx_log.size()) ? 32'(tx_log[i]) : 32'hDEAD, 32'(burst_exp[i]));
            chk("burst_rd_addr", (i < rd_log.size()) ? 32'(rd_log[i]) : 32'hDEAD, 32'(i));
        end
        cs_off();

        // Write burst starting at 0x02.
        clr_logs();
        cs_on();
        send(8'h82, 3);
        send(8'h01, 3);
        send(8'h03, 3);
        chk("write_count", 32'(wr_log.size()), 32'(2));
        chk("write_0", (wr_log.size() > 0) ? 32'(wr_log[0]) : 32'hDEAD, 32'h0201);
        chk("write_1", (wr_log.size() > 1) ? 32'(wr_log[1]) : 32'hDEAD, 32'h0303);
        chk("write_no_rd", 32'(rd_log.size()), 32'(0));
        chk("write_no_tx", 32'(tx_log.size()), 32'(0));
        cs_off();

        // Address wrap.
        clr_logs();
        cs_on();
        send(8'h7F, 4);
        send(8'h00, 4);
        send(8'h00, 4);
        chk("wrap_count", 32'(rd_log.size()), 32'(3));
        chk("wrap_0", (rd_log.size() > 0) ? 32'(rd_log[0]) : 32'hDEAD, 32'h7F);
        chk("wrap_1", (rd_log.size() > 1) ? 32'(rd_log[1]) : 32'hDEAD, 32'h00);
        chk("wrap_2", (rd_log.size() > 2) ? 32'(rd_log[2]) : 32'hDEAD, 32'h01);
        cs_off();

        // Overrun: second byte two cycles after the read command.
        clr_logs();
        cs_on();
        send(8'h10, 1);
        send(8'h00, 6);
        chk("overrun_set", 32'(overrun), 32'(1));
        chk("overrun_one_load", 32'(tx_log.size()), 32'(1));
        cs_off();
        chk("overrun_sticky_idle", 32'(overrun), 32'(1));
        cs_on();
        chk("overrun_cleared", 32'(overrun), 32'(0));
        cs_off();

        // Abort: cs drops the cycle after reg_rd_en.
        clr_logs();
        cs_on();
        send(8'h20, 1);
        cs_active = 1'b0;
        cyc(5);
        chk("abort_rd_count", 32'(rd_log.size()), 32'(1));
        chk("abort_no_tx", 32'(tx_log.size()), 32'(0));
        send(8'h55, 3);
        chk("cs_low_rx_ignored", 32'(rd_log.size() + wr_log.size() + tx_log.size()), 32'(1));

        // Falling edge and byte in the same cycle: byte ignored.
        clr_logs();
        cs_on();
        send(8'h81, 2);
        cs_active = 1'b0; rx_valid = 1'b1; rx_byte = 8'h77;
        cyc(1);
        rx_valid = 1'b0;
        cyc(3);
        chk("fall_wins", 32'(wr_log.size()), 32'(0));

        // Reset pulsed during a write strobe.
        cs_on();
        send(8'h85, 3);
        send(8'h11, 0);
        #1 rst_n = 1'b0;
        #1;
        chk_reset_outputs("midreset");
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        clr_logs();
        send(8'h22, 2);
        send(8'h90, 2);
        cyc(3);
        chk("post_reset_no_strobe", 32'(wr_log.size() + rd_log.size() + tx_log.size()), 32'(0));
        cs_off();
        cs_on();
        send(8'h83, 2);
        send(8'h44, 3);
        chk("post_reset_write", (wr_log.size() > 0) ? 32'(wr_log[0]) : 32'hDEAD, 32'h0344);
        cs_off();

        // Randomized transactions checked cycle by cycle by the model.
        for (int t = 0; t < 60; t++) begin
            int nb;
            cs_active = 1'b1;
            cyc(int'($urandom_range(1, 2)));
            send(8'($urandom_range(0, 255)), int'($urandom_range(0, 5)));
            nb = int'($urandom_range(0, 6));
            for (int j = 0; j < nb; j++) begin
                if ($urandom_range(0, 15) == 0) break;
                send(8'($urandom_range(0, 255)), int'($urandom_range(0, 5)));
            end
            if ($urandom_range(0, 2) == 0) begin
                rx_valid = 1'b1; rx_byte = 8'($urandom_range(0, 255));
            end
            cs_active = 1'b0;
            cyc(1);
            rx_valid = 1'b0;
            if ($urandom_range(0, 3) == 0) send(8'($urandom_range(0, 255)), 1);
            cyc(int'($urandom_range(1, 4)));
        end

        cyc(2);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/spi_reg_bridge.md
SPI_REG_BRIDGE -- requirements
Module: spi_reg_bridge

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 7, register address width.
REQ-002 The block SHALL have parameter AUTO_INC, default 1; 1 = post-increment address per data byte, 0 = hold address.
REQ-003 Port: clk  input  1  single system clock; all logic on its rising edge.
REQ-004 Port: rst_n  input  1  asynchronous, active-low reset.
REQ-005 Port: cs_active  input  1  chip select asserted, already synchronised to clk.
REQ-006 Port: rx_valid  input  1  one-cycle pulse, complete byte received from the SPI byte slave.
REQ-007 Port: rx_byte  input  8  received byte, valid with rx_valid.
REQ-008 Port: tx_load  output  1  one-cycle pulse, tx_byte to be loaded into the slave shift buffer.
REQ-009 Port: tx_byte  output  8  byte for the slave to transmit.
REQ-010 Port: reg_addr  output  ADDR_W  register file address.
REQ-011 Port: reg_rd_en  output  1  one-cycle read strobe.
REQ-012 Port: reg_rd_data  input  8  read data, valid exactly one cycle after reg_rd_en.
REQ-013 Port: reg_wr_en  output  1  one-cycle write strobe.
REQ-014 Port: reg_wr_data  output  8  write data, valid with reg_wr_en.
REQ-015 Port: overrun  output  1  sticky flag, byte dropped during the current transaction.

Function
REQ-016 States SHALL be IDLE, CMD, RD_ISSUE, RD_CAPT, RD_LOAD, RD_READY, WR_READY.
REQ-017 IDLE -> CMD on cs_active rising edge; overrun cleared on the same edge.
REQ-018 In CMD, first rx_valid (cycle T): bit7 = 1 -> write, bit7 = 0 -> read; reg_addr <= rx_byte[ADDR_W-1:0]; write -> WR_READY, read -> RD_ISSUE.
REQ-019 Read pipeline: reg_rd_en high in T+1 with reg_addr; reg_rd_data sampled at end of T+2; tx_load high and tx_byte = sampled data in T+3; then RD_READY.
REQ-020 Address post-increments (AUTO_INC = 1) in the cycle after reg_rd_en, so the next read targets addr+1.
REQ-021 In RD_READY, each rx_valid (received byte ignored) restarts the read pipeline of REQ-019 at the current reg_addr.
REQ-022 In WR_READY, each rx_valid at T: reg_wr_en high in T+1, reg_wr_data = rx_byte, reg_addr = current address; address increments after the strobe.
REQ-023 Address increments modulo 2^ADDR_W (0x7F -> 0x00 for ADDR_W = 7).
REQ-024 rx_valid in RD_ISSUE, RD_CAPT or RD_LOAD: byte dropped, overrun set, the pipeline in flight completes unchanged.
REQ-025 rx_valid while cs_active = 0: ignored, no strobes.
REQ-026 cs_active falling edge in any state: next state IDLE; a pending read capture and its tx_load are suppressed; no reg_rd_en or reg_wr_en issued after the edge.
REQ-027 cs_active falling and rx_valid in the same cycle: falling edge wins, byte ignored.
REQ-028 At most one of reg_rd_en and reg_wr_en SHALL be high in any cycle.
REQ-029 tx_byte holds its last value between tx_load pulses.

Reset
REQ-030 On rst_n low, immediately: state IDLE; tx_load, reg_rd_en, reg_wr_en, overrun = 0; tx_byte, reg_addr, reg_wr_data = 0.
REQ-031 Reset assertion mid-transaction aborts the transaction with no further strobes; after release, the block waits for a new cs_active rising edge (cs_active already high at release does not start a transaction).

Verification
REQ-032 Read burst: cs high, bytes 0x00, 0xFF x6, with register file holding "ARGUS", 0x01 at 0x00-0x05 -> tx_load sequence 0x41, 0x52, 0x47, 0x55, 0x53, 0x01, then data from 0x06; reg_rd_en addresses 0x00..0x06.
REQ-033 Write: cs high, bytes 0x82, 0x01, 0x03 -> reg_wr_en at addr 0x02 data 0x01, then addr 0x03 data 0x03; no reg_rd_en, no tx_load.
REQ-034 Wrap: read command 0x7F, two further bytes -> reads at 0x7F, 0x00, 0x01.
REQ-035 Overrun: read command, second rx_valid two cycles later -> overrun = 1, one tx_load only; overrun clears on the next cs rising edge.
REQ-036 Abort: cs falls in the cycle after reg_rd_en -> no tx_load, state IDLE; rst_n pulsed mid-write burst -> all outputs 0 immediately, no strobe until new cs rising edge.
